// File: rtl/dtcm_if.sv
// LSU <-> DTCM command/response channel.
// The LSU drives commands and response back-pressure; the DTCM controller
// answers with command ready and the response itself.
interface dtcm_if #(
    parameter int DW = 32,
    parameter int AW = 16
);
    logic            dtcm_cmd_valid;
    logic            dtcm_cmd_ready;
    logic            dtcm_cmd_read;
    logic [AW-1:0]   dtcm_cmd_addr;
    logic [DW-1:0]   dtcm_cmd_wdata;
    logic [DW/8-1:0] dtcm_cmd_wmask;
    logic            dtcm_rsp_valid;
    logic            dtcm_rsp_ready;
    logic [DW-1:0]   dtcm_rsp_rdata;

    modport master (
        output dtcm_cmd_valid,
        output dtcm_cmd_read,
        output dtcm_cmd_addr,
        output dtcm_cmd_wdata,
        output dtcm_cmd_wmask,
        output dtcm_rsp_ready,
        input  dtcm_cmd_ready,
        input  dtcm_rsp_valid,
        input  dtcm_rsp_rdata
    );

    modport slave (
        input  dtcm_cmd_valid,
        input  dtcm_cmd_read,
        input  dtcm_cmd_addr,
        input  dtcm_cmd_wdata,
        input  dtcm_cmd_wmask,
        input  dtcm_rsp_ready,
        output dtcm_cmd_ready,
        output dtcm_rsp_valid,
        output dtcm_rsp_rdata
    );
endinterface

// File: rtl/dtcm_ctrl.sv
// DTCM controller: responder end of the LSU command/response channel,
// driving a single-port synchronous SRAM with one-cycle read latency.
// Exactly one response is returned per accepted command; read data is
// parked in hold_q while the response is back-pressured.
module dtcm_ctrl #(
    parameter int DW     = 32,
    parameter int AW     = 16,
    parameter int RAM_AW = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    dtcm_if.slave             bus,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW/8-1:0]   ram_wem,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RSP  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    logic          rsp_valid_q;
    logic          rd_flag;
    logic [DW-1:0] hold_q;
    logic [DW-1:0] rdata;
    logic          cmd_ready;
    logic          cmd_hsk;
    logic          rsp_hsk;

    // Only one response may be outstanding, so a new command is taken only
    // when the slot is empty or is being drained this very cycle.
    assign cmd_ready = ~rsp_valid_q | bus.dtcm_rsp_ready;
    assign cmd_hsk   = bus.dtcm_cmd_valid & cmd_ready;
    assign rsp_hsk   = rsp_valid_q & bus.dtcm_rsp_ready;

    assign bus.dtcm_cmd_ready = cmd_ready;
    assign bus.dtcm_rsp_valid = rsp_valid_q;
    assign bus.dtcm_rsp_rdata = rdata;

    // SRAM is driven straight from the accepted command; the word address
    // drops the byte offset and any bits above the macro, so addresses alias.
    assign ram_cs   = cmd_hsk;
    assign ram_we   = cmd_hsk & ~bus.dtcm_cmd_read;
    assign ram_addr = bus.dtcm_cmd_addr[RAM_AW+1:2];
    assign ram_wem  = bus.dtcm_cmd_wmask;
    assign ram_din  = bus.dtcm_cmd_wdata;

    generate
        if (AW > RAM_AW + 2) begin : g_addr_hi
            logic unused_addr_bits;
            assign unused_addr_bits = ^{bus.dtcm_cmd_addr[AW-1:RAM_AW+2],
                                        bus.dtcm_cmd_addr[1:0]};
        end else begin : g_addr_lo
            logic unused_addr_bits;
            assign unused_addr_bits = ^bus.dtcm_cmd_addr[1:0];
        end
    endgenerate

    // Response data: live SRAM output in the first response cycle, the
    // parked copy while stalled, zero for stores and when idle.
    always_comb begin
        rdata = '0;
        case (state)
            RSP:     rdata = rd_flag ? ram_dout : '0;
            HOLD:    rdata = hold_q;
            default: rdata = '0;
        endcase
    end

    // Response FSM with registered valid, load/store flag and holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            rd_flag     <= 1'b0;
            hold_q      <= '0;
        end else begin
            if (cmd_hsk) begin
                rd_flag <= bus.dtcm_cmd_read;
            end
            case (state)
                IDLE: begin
                    if (cmd_hsk) begin
                        state       <= RSP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_hsk) begin
                        if (!cmd_hsk) begin
                            state       <= IDLE;
                            rsp_valid_q <= 1'b0;
                        end
                    end else begin
                        state  <= HOLD;
                        hold_q <= rd_flag ? ram_dout : '0;
                    end
                end
                HOLD: begin
                    if (rsp_hsk) begin
                        if (cmd_hsk) begin
                            state <= RSP;
                        end else begin
                            state       <= IDLE;
                            rsp_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
